// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
package fb_pkg;

    // One bank holds a full 320x180 stored frame.
    localparam int unsigned FB_DEPTH = 57600;

    // Writer handshake encodings on fb_ready_to_switch_out.
    localparam logic [1:0] FB_FREE     = 2'b11;
    localparam logic [1:0] FB_PENDING  = 2'b01;
    localparam logic [1:0] FB_SWAPPING = 2'b10;

    typedef enum logic [1:0] {
        StWrite,
        StPending,
        StSwap
    } t_fb_state;

    // Row-to-linear-offset for 320-wide rows, built from two shifts instead of a multiplier.
    function automatic logic [15:0] mul320(input logic [15:0] v);
        return (v << 8) + (v << 6);
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Writer-side bus: scattered pixel writes in, swap-readiness handshake out.
interface frame_buffer_if #(
    parameter int unsigned PIXEL_WIDTH = 16
);
    logic                   ray_valid_in;
    logic [15:0]            ray_address_in;
    logic [PIXEL_WIDTH-1:0] ray_pixel_in;
    logic                   ray_last_pixel_in;
    logic [1:0]             fb_ready_to_switch_out;

    // Upstream ray-flattening stage.
    modport master (
        output ray_valid_in,
        output ray_address_in,
        output ray_pixel_in,
        output ray_last_pixel_in,
        input  fb_ready_to_switch_out
    );

    // Frame buffer.
    modport slave (
        input  ray_valid_in,
        input  ray_address_in,
        input  ray_pixel_in,
        input  ray_last_pixel_in,
        output fb_ready_to_switch_out
    );
endinterface

// File: rtl/fb_bank_ram.sv
// One frame bank: simple dual-port BRAM, registered read address and registered read data.
module fb_bank_ram
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = FB_DEPTH,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [WIDTH-1:0]      rd_data_q;

    // Write port; the caller guarantees wr_addr < DEPTH whenever we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: address register then output register, two cycles address-to-data.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_addr_q <= rd_addr;
        end
        rd_data_q <= mem[rd_addr_q];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 320x180 frame store: writer fills the back bank, display reads the
// front bank 4x upscaled, banks swap only at a display frame boundary.
module frame_buffer
    import fb_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH        = 16,
    parameter int unsigned SCREEN_WIDTH       = 320,
    parameter int unsigned SCREEN_HEIGHT      = 180,
    parameter int unsigned FULL_SCREEN_WIDTH  = 1280,
    parameter int unsigned FULL_SCREEN_HEIGHT = 720
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    frame_buffer_if.slave          ray,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   active_draw_in,
    input  logic                   new_frame_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_valid_out,
    output logic [7:0]             swap_count_out
);

    localparam int unsigned DEPTH   = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam int unsigned H_SHIFT = $clog2(FULL_SCREEN_WIDTH / SCREEN_WIDTH);
    localparam int unsigned V_SHIFT = $clog2(FULL_SCREEN_HEIGHT / SCREEN_HEIGHT);

    t_fb_state state_q, state_d;
    logic      back_sel_q, back_sel_d;
    logic [7:0] swap_count_q, swap_count_d;
    logic      wr_en;
    logic      wr_ok;

    // Write side: only in-range, valid writes count; a dropped write never ends a frame.
    assign wr_ok = ray.ray_valid_in && (ray.ray_address_in < DEPTH_W);

    // Swap control state, bank select and swap counter.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q      <= StWrite;
            back_sel_q   <= 1'b0;
            swap_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            back_sel_q   <= back_sel_d;
            swap_count_q <= swap_count_d;
        end
    end

    // Next-state and handshake decode; new_frame_in is only honoured once the frame is complete.
    always_comb begin
        state_d      = state_q;
        back_sel_d   = back_sel_q;
        swap_count_d = swap_count_q;
        wr_en        = 1'b0;
        ray.fb_ready_to_switch_out = FB_FREE;
        case (state_q)
            StWrite: begin
                ray.fb_ready_to_switch_out = FB_FREE;
                wr_en = wr_ok;
                if (wr_ok && ray.ray_last_pixel_in) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                ray.fb_ready_to_switch_out = FB_PENDING;
                if (new_frame_in) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                ray.fb_ready_to_switch_out = FB_SWAPPING;
                back_sel_d   = ~back_sel_q;
                swap_count_d = swap_count_q + 8'd1;
                state_d      = StWrite;
            end
            default: begin
                state_d = StWrite;
            end
        endcase
    end

    assign swap_count_out = swap_count_q;

    // Read side: downscale display coordinates and linearise.
    logic [10:0] col;
    logic [9:0]  row;
    logic [15:0] rd_addr;

    assign col     = hcount_in >> H_SHIFT;
    assign row     = vcount_in >> V_SHIFT;
    assign rd_addr = {5'b0, col} + mul320({6'b0, row});

    logic [PIXEL_WIDTH-1:0] rd_data0, rd_data1;

    fb_bank_ram #(
        .WIDTH      (PIXEL_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (16)
    ) u_bank0 (
        .clk     (pixel_clk_in),
        .we      (wr_en && !back_sel_q),
        .wr_addr (ray.ray_address_in),
        .wr_data (ray.ray_pixel_in),
        .rd_en   (active_draw_in && back_sel_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    fb_bank_ram #(
        .WIDTH      (PIXEL_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (16)
    ) u_bank1 (
        .clk     (pixel_clk_in),
        .we      (wr_en && back_sel_q),
        .wr_addr (ray.ray_address_in),
        .wr_data (ray.ray_pixel_in),
        .rd_en   (active_draw_in && !back_sel_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    // Delay the front-bank select and active flag to match the two-cycle BRAM read.
    logic valid_q1, valid_q2;
    logic front_q1, front_q2;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            valid_q1 <= 1'b0;
            valid_q2 <= 1'b0;
            front_q1 <= 1'b1;
            front_q2 <= 1'b1;
        end else begin
            valid_q1 <= active_draw_in;
            valid_q2 <= valid_q1;
            front_q1 <= ~back_sel_q;
            front_q2 <= front_q1;
        end
    end

    assign pixel_valid_out = valid_q2;
    assign pixel_out       = valid_q2 ? (front_q2 ? rd_data1 : rd_data0) : '0;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: stimulus pushes expectations, a negedge monitor checks.
module tb_frame_buffer;

    localparam int K_READY = 0;
    localparam int K_SWAP  = 1;
    localparam int K_VALID = 2;
    localparam int K_PIX   = 3;
    localparam int K_DRAIN = 4;

    typedef struct {
        int kind;
        int exp;
        int tag;
    } chk_t;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        active_draw;
    logic        new_frame;
    logic [15:0] pixel_out;
    logic        pixel_valid;
    logic [7:0]  swap_count;

    frame_buffer_if #(.PIXEL_WIDTH(16)) ray_bus ();

    frame_buffer dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst),
        .ray             (ray_bus),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .active_draw_in  (active_draw),
        .new_frame_in    (new_frame),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid),
        .swap_count_out  (swap_count)
    );

    int   pix_q[$];
    int   pix_tag_q[$];
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: sole owner of the counters.
    initial begin
        int   act;
        int   e;
        int   t;
        chk_t c;
        forever begin
            @(negedge clk);
            if (pixel_valid) begin
                n_checks++;
                if (pix_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pixel_unexpected: got %0d, required no valid pixel", pixel_out);
                end else begin
                    e = pix_q.pop_front();
                    t = pix_tag_q.pop_front();
                    if (32'(pixel_out) != e) begin
                        n_fail++;
                        $display("FAIL pixel step %0d: got %0d, required %0d", t, pixel_out, e);
                    end
                end
            end
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                n_checks++;
                case (c.kind)
                    K_READY: act = 32'(ray_bus.fb_ready_to_switch_out);
                    K_SWAP:  act = 32'(swap_count);
                    K_VALID: act = 32'(pixel_valid);
                    K_PIX:   act = 32'(pixel_out);
                    K_DRAIN: act = pix_q.size();
                    default: act = -1;
                endcase
                if (act != c.exp) begin
                    n_fail++;
                    case (c.kind)
                        K_READY: $display("FAIL ready step %0d: got %0d, required %0d", c.tag, act, c.exp);
                        K_SWAP:  $display("FAIL swap_count step %0d: got %0d, required %0d", c.tag, act, c.exp);
                        K_VALID: $display("FAIL pixel_valid step %0d: got %0d, required %0d", c.tag, act, c.exp);
                        K_PIX:   $display("FAIL pixel_idle step %0d: got %0d, required %0d", c.tag, act, c.exp);
                        default: $display("FAIL drain step %0d: got %0d, required %0d", c.tag, act, c.exp);
                    endcase
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checked at the next negedge, i.e. against the current cycle.
    task automatic chk(input int kind, input int exp);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.tag  = step;
        chk_q.push_back(c);
    endtask

    task automatic wr(input int a, input int p, input bit last, input bit nf);
        ray_bus.ray_valid_in      = 1'b1;
        ray_bus.ray_address_in    = 16'(a);
        ray_bus.ray_pixel_in      = 16'(p);
        ray_bus.ray_last_pixel_in = last;
        new_frame                 = nf;
        tick();
        ray_bus.ray_valid_in      = 1'b0;
        ray_bus.ray_last_pixel_in = 1'b0;
        new_frame                 = 1'b0;
    endtask

    task automatic rd(input int h, input int v, input int exp);
        hcount      = 11'(h);
        vcount      = 10'(v);
        active_draw = 1'b1;
        pix_q.push_back(exp);
        pix_tag_q.push_back(step);
        tick();
    endtask

    task automatic end_reads();
        active_draw = 1'b0;
        hcount      = 11'd8;
        vcount      = 10'd4;
        tick();
        tick();
        chk(K_VALID, 0);
        chk(K_PIX, 0);
    endtask

    task automatic pulse_nf();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hcount = '0;
        vcount = '0;
        active_draw = 1'b0;
        new_frame = 1'b0;
        ray_bus.ray_valid_in = 1'b0;
        ray_bus.ray_address_in = '0;
        ray_bus.ray_pixel_in = '0;
        ray_bus.ray_last_pixel_in = 1'b0;

        // Reset state.
        step = 1;
        repeat (3) tick();
        chk(K_READY, 3);
        chk(K_SWAP, 0);
        chk(K_VALID, 0);
        chk(K_PIX, 0);
        rst = 1'b0;
        tick();
        chk(K_READY, 3);
        chk(K_SWAP, 0);

        // Fill bank 0 with pixel = address; out-of-range writes just before the last pixel.
        step = 2;
        for (int a = 0; a < 57600; a++) begin
            if (a == 57599) begin
                wr(57600, 16'hBEEF, 1'b0, 1'b0);
                wr(65535, 16'hBEEF, 1'b0, 1'b0);
                chk(K_READY, 3);
            end
            wr(a, a, a == 57599, 1'b0);
        end
        chk(K_READY, 1);

        // Writes while pending are dropped, even with the last flag.
        step = 3;
        wr(322, 16'h1234, 1'b0, 1'b0);
        chk(K_READY, 1);
        wr(323, 16'h1234, 1'b1, 1'b0);
        chk(K_READY, 1);
        pulse_nf();
        chk(K_READY, 2);
        chk(K_SWAP, 0);
        tick();
        chk(K_READY, 3);
        chk(K_SWAP, 1);

        // Display sweep from front bank 0.
        step = 4;
        rd(8, 4, 322);
        rd(0, 0, 0);
        rd(3, 3, 0);
        rd(4, 0, 1);
        rd(1279, 719, 57599);
        rd(1279, 0, 319);
        rd(0, 4, 320);
        rd(7, 7, 321);
        end_reads();

        // Last pixel coincident with new_frame: pending, no swap until the next pulse.
        step = 5;
        wr(322, 16'hAAAA, 1'b1, 1'b1);
        chk(K_READY, 1);
        tick();
        tick();
        chk(K_READY, 1);
        chk(K_SWAP, 1);
        rd(8, 4, 322);
        end_reads();
        pulse_nf();
        chk(K_READY, 2);
        rd(8, 4, 322);          // issued on the swap cycle: old front
        chk(K_READY, 3);
        chk(K_SWAP, 2);
        rd(8, 4, 16'hAAAA);     // new front is bank 1
        end_reads();

        // One more swap so back_sel is 1, then reset while pending.
        step = 6;
        wr(322, 16'hBBBB, 1'b1, 1'b0);
        chk(K_READY, 1);
        pulse_nf();
        tick();
        chk(K_READY, 3);
        chk(K_SWAP, 3);
        rd(8, 4, 16'hBBBB);
        end_reads();
        wr(1, 16'h7777, 1'b1, 1'b0);
        chk(K_READY, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(K_READY, 3);
        chk(K_SWAP, 0);
        chk(K_VALID, 0);
        pulse_nf();
        chk(K_READY, 3);
        tick();
        chk(K_READY, 3);
        chk(K_SWAP, 0);
        rd(8, 4, 16'hAAAA);     // back_sel back to 0: front is bank 1
        rd(4, 0, 16'h7777);
        end_reads();

        // 256 write/swap rounds: counter wraps, front bank alternates.
        step = 7;
        for (int i = 0; i < 256; i++) begin
            wr(0, i + 256, 1'b1, 1'b0);
            pulse_nf();
            tick();
            chk(K_SWAP, (i + 1) % 256);
            rd(0, 0, i + 256);
            rd(4, 0, (i % 2 == 0) ? 1 : 16'h7777);
            end_reads();
        end
        chk(K_SWAP, 0);
        chk(K_READY, 3);

        step = 8;
        repeat (4) tick();
        chk(K_DRAIN, 0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
